iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 222 ++++++++++++++++++++++
 tb/tb_iter_alu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: W-bit ALU with single-cycle logic/arith/shift ops plus an
// iterative signed multiplier (one shift-add step per cycle) and an
// optional iterative unsigned restoring divider.
// Build macro: ITER_ALU_DIV_EN -- when defined, op 4 runs the W-step divider;
// when undefined, op 4 completes in one cycle with r=r2=0, cf=1.
module iter_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r,
  output logic [W-1:0] r2,
  output logic         of,
  output logic         cf,
  output logic         eq
);
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST = SW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;

  logic                  accept, go_mul, go_div, last_step;
  logic [3:0]            op_p0;
  logic [W-1:0]          x_p0, y_p0;
  logic signed [W-1:0]   xs_p0, ys_p0;
  logic                  vld_p0;
  logic [SW-1:0]         cnt_p0;
  logic signed [2*W-1:0] prod_p0, mcand_p0, addend;
  logic [W-1:0]          mplier_p0;
  logic                  vld_mul_p1;
  logic [SW-1:0]         sh;
  logic [W:0]            add_s, sub_s;
  logic [W-1:0]          alu_r, alu_r2;
  logic                  alu_of, alu_cf;
`ifdef ITER_ALU_DIV_EN
  logic [W-1:0]          rem_p0, quo_p0;
  logic [W:0]            rem_sh, rem_diff;
  logic                  vld_div_p1;
`endif

  assign busy      = (state != IDLE);
  assign accept    = start && !busy && !rst;
  assign go_mul    = accept && (op == 4'd3);
`ifdef ITER_ALU_DIV_EN
  assign go_div    = accept && (op == 4'd4) && (y != '0);
`else
  assign go_div    = 1'b0;
`endif
  assign last_step = (cnt_p0 == LAST);
  assign xs_p0     = x_p0;
  assign ys_p0     = y_p0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: multi-cycle ops leave IDLE on acceptance, return after W steps
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (go_mul) state_nx = MUL;
                else if (go_div) state_nx = DIV;
      MUL, DIV: if (last_step) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Control: valid flags and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_mul_p1 <= 1'b0;
      cnt_p0     <= '0;
`ifdef ITER_ALU_DIV_EN
      vld_div_p1 <= 1'b0;
`endif
    end else begin
      vld_p0     <= accept && !go_mul && !go_div;
      vld_mul_p1 <= (state == MUL) && last_step;
      cnt_p0     <= busy ? cnt_p0 + SW'(1) : '0;
`ifdef ITER_ALU_DIV_EN
      vld_div_p1 <= (state == DIV) && last_step;
`endif
    end
  end

  // Multiplier step: the top multiplier bit carries negative weight
  always_comb begin
    addend = '0;
    if (mplier_p0[0]) addend = last_step ? -mcand_p0 : mcand_p0;
  end

`ifdef ITER_ALU_DIV_EN
  // Divider step: shift in next dividend bit, trial-subtract the divisor
  always_comb begin
    rem_sh   = {rem_p0, quo_p0[W-1]};
    rem_diff = rem_sh - {1'b0, y_p0};
  end
`endif

  // ---- stage p0: operand capture and iterative datapath ----
  // Operands latch on acceptance and hold while busy, so input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= op;
      x_p0      <= x;
      y_p0      <= y;
      prod_p0   <= '0;
      mcand_p0  <= {{W{x[W-1]}}, x};
      mplier_p0 <= y;
`ifdef ITER_ALU_DIV_EN
      rem_p0    <= '0;
      quo_p0    <= x;
`endif
    end else if (state == MUL) begin
      prod_p0   <= prod_p0 + addend;
      mcand_p0  <= mcand_p0 <<< 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
`ifdef ITER_ALU_DIV_EN
    else if (state == DIV) begin
      if (!rem_diff[W]) begin
        rem_p0 <= rem_diff[W-1:0];
        quo_p0 <= {quo_p0[W-2:0], 1'b1};
      end else begin
        rem_p0 <= rem_sh[W-1:0];
        quo_p0 <= {quo_p0[W-2:0], 1'b0};
      end
    end
`endif
  end

  // Single-cycle result from the captured operands
  always_comb begin
    alu_r  = '0;
    alu_r2 = '0;
    alu_of = 1'b0;
    alu_cf = 1'b0;
    sh     = y_p0[SW-1:0];
    add_s  = {1'b0, x_p0} + {1'b0, y_p0};
    sub_s  = {1'b0, x_p0} - {1'b0, y_p0};
    case (op_p0)
      4'd0: alu_r = x_p0 << sh;
      4'd1: alu_r = xs_p0 >>> sh;
      4'd2: alu_r = x_p0 >> sh;
      4'd4: begin
`ifdef ITER_ALU_DIV_EN
        // only divide-by-zero reaches here
        alu_r  = '1;
        alu_r2 = x_p0;
`endif
        alu_cf = 1'b1;
      end
      4'd5: begin
        alu_r  = add_s[W-1:0];
        alu_cf = add_s[W];
        alu_of = (x_p0[W-1] == y_p0[W-1]) && (add_s[W-1] != x_p0[W-1]);
      end
      4'd6: begin
        alu_r  = sub_s[W-1:0];
        alu_cf = sub_s[W];
        alu_of = (x_p0[W-1] != y_p0[W-1]) && (sub_s[W-1] != x_p0[W-1]);
      end
      4'd7:  alu_r = x_p0 & y_p0;
      4'd8:  alu_r = x_p0 | y_p0;
      4'd9:  alu_r = x_p0 ^ y_p0;
      4'd10: alu_r = ~(x_p0 | y_p0);
      4'd11: alu_r = {{(W-1){1'b0}}, (xs_p0 < ys_p0)};
      4'd12: alu_r = {{(W-1){1'b0}}, (x_p0 < y_p0)};
      default: ;
    endcase
  end

  // ---- stage p1: result registers, held until the next completion ----
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      r    <= '0;
      r2   <= '0;
      of   <= 1'b0;
      cf   <= 1'b0;
      eq   <= 1'b0;
    end else begin
`ifdef ITER_ALU_DIV_EN
      done <= vld_p0 || vld_mul_p1 || vld_div_p1;
`else
      done <= vld_p0 || vld_mul_p1;
`endif
      if (vld_p0) begin
        r  <= alu_r;
        r2 <= alu_r2;
        of <= alu_of;
        cf <= alu_cf;
        eq <= (x_p0 == y_p0);
      end else if (vld_mul_p1) begin
        r  <= prod_p0[W-1:0];
        r2 <= prod_p0[2*W-1:W];
        of <= 1'b0;
        cf <= 1'b0;
        eq <= (x_p0 == y_p0);
      end
`ifdef ITER_ALU_DIV_EN
      else if (vld_div_p1) begin
        r  <= quo_p0;
        r2 <= rem_p0;
        of <= 1'b0;
        cf <= 1'b0;
        eq <= (x_p0 == y_p0);
      end
`endif
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and random checks of iter_alu against an
// arithmetic reference model (W=32). Follows ITER_ALU_DIV_EN if defined.
module tb_iter_alu;
  localparam int W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [31:0] x, y;
  logic        busy, done;
  logic [31:0] r, r2;
  logic        of, cf, eq;
  int total = 0;
  int bad   = 0;

  iter_alu #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .r(r), .r2(r2), .of(of), .cf(cf), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with plain wide arithmetic
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] er, output logic [31:0] er2,
                                output logic eof, output logic ecf, output bit multi);
    longint sa, sb, s, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    er = 32'd0; er2 = 32'd0; eof = 1'b0; ecf = 1'b0; multi = 1'b0;
    case (o)
      4'd0: er = a << b[4:0];
      4'd1: er = $signed(a) >>> b[4:0];
      4'd2: er = a >> b[4:0];
      4'd3: begin p = sa * sb; {er2, er} = p; multi = 1'b1; end
      4'd4: begin
`ifdef ITER_ALU_DIV_EN
        if (b == 32'd0) begin er = 32'hFFFF_FFFF; er2 = a; ecf = 1'b1; end
        else begin er = a / b; er2 = a % b; multi = 1'b1; end
`else
        ecf = 1'b1;
`endif
      end
      4'd5: begin
        s = sa + sb; er = a + b;
        ecf = (longint'(a) + longint'(b)) >= 64'sh1_0000_0000;
        eof = (s > MAXI) || (s < MINI);
      end
      4'd6: begin
        s = sa - sb; er = a - b;
        ecf = (a < b);
        eof = (s > MAXI) || (s < MINI);
      end
      4'd7:  er = a & b;
      4'd8:  er = a | b;
      4'd9:  er = a ^ b;
      4'd10: er = ~(a | b);
      4'd11: er = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: er = (a < b) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endfunction

  // Issue one request, check timing/busy behaviour and the completed result
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er, er2;
    logic        eof, ecf;
    bit          multi;
    int          nb, nd;
    model(o, a, b, er, er2, eof, ecf, multi);
    @(negedge clk); start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); x = $urandom; y = $urandom;
    if (multi) begin
      nb = 0; nd = 0;
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        if (busy === 1'b1) nb++;
        if (done !== 1'b0) nd++;
        if (k == 3) begin start = 1'b1; op = 4'd5; end
        if (k == 4) start = 1'b0;
      end
      chk({tag, "_busy_cycles"}, 64'(nb), 64'(W));
      chk({tag, "_early_done"}, 64'(nd), 64'd0);
      @(negedge clk);
      chk({tag, "_gap_busy"}, 64'(busy), 64'd0);
      chk({tag, "_gap_done"}, 64'(done), 64'd0);
    end else begin
      @(negedge clk);
      chk({tag, "_pend_done"}, 64'(done), 64'd0);
      chk({tag, "_pend_busy"}, 64'(busy), 64'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_r"},  64'(r),  64'(er));
    chk({tag, "_r2"}, 64'(r2), 64'(er2));
    chk({tag, "_of"}, 64'(of), 64'(eof));
    chk({tag, "_cf"}, 64'(cf), 64'(ecf));
    chk({tag, "_eq"}, 64'(eq), 64'(a == b));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold_r"}, 64'(r), 64'(er));
  endtask

  initial begin
    logic [3:0]  qo[4];
    logic [31:0] qa[4], qb[4];
    logic [31:0] er, er2;
    logic        eof, ecf;
    bit          multi;
    int          nd;
    logic [3:0]  o;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; op = 4'd0; x = 32'd0; y = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_r",    64'(r),    64'd0);
    chk("rst_r2",   64'(r2),   64'd0);
    chk("rst_flags", 64'({of, cf, eq}), 64'd0);

    // directed cases
    run(4'd5,  32'h7FFF_FFFF, 32'd1,         "add_ovf");
    run(4'd3,  32'hFFFF_FFFE, 32'd3,         "mul_neg");
    run(4'd4,  32'd100,       32'd7,         "div");
    run(4'd4,  32'd5,         32'd0,         "div0");
    run(4'd1,  32'h8000_0000, 32'h24,        "sra");
    run(4'd6,  32'd1,         32'd2,         "sub_borrow");
    run(4'd0,  32'd1,         32'h3F,        "sll31");
    run(4'd2,  32'h8000_0000, 32'h21,        "srl_lowbits");
    run(4'd5,  32'hFFFF_FFFF, 32'd1,         "add_carry");
    run(4'd6,  32'h8000_0000, 32'd1,         "sub_ovf");
    run(4'd11, 32'hFFFF_FFFF, 32'd1,         "slt");
    run(4'd12, 32'hFFFF_FFFF, 32'd1,         "sltu");
    run(4'd3,  32'h8000_0000, 32'h8000_0000, "mul_minmin");
    run(4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1m1");
    run(4'd4,  32'hFFFF_FFFF, 32'd1,         "div_by1");
    run(4'd4,  32'd7,         32'hFFFF_FFFF, "div_small");
    run(4'd10, 32'h0000_F0F0, 32'h0000_0F0F, "nor");
    run(4'd13, 32'd5,         32'd5,         "op13");
    run(4'd15, 32'd1,         32'd2,         "op15");

    // reset aborts a multiply in flight
    @(negedge clk); start = 1'b1; op = 4'd3; x = 32'd12345; y = 32'd678;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_r",    64'(r),    64'd0);
    chk("abort_r2",   64'(r2),   64'd0);
    chk("abort_flags", 64'({of, cf, eq}), 64'd0);
    nd = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done !== 1'b0) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run(4'd7, 32'hF0, 32'h3C, "and_after_abort");

    // reset wins over a simultaneous start
    @(negedge clk); rst = 1'b1; start = 1'b1; op = 4'd5; x = 32'd7; y = 32'd7;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rstpri_done0", 64'(done), 64'd0);
    chk("rstpri_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rstpri_done1", 64'(done), 64'd0);
    chk("rstpri_eq", 64'(eq), 64'd0);

    // back-to-back single-cycle ops: done every cycle
    qo[0] = 4'd5; qo[1] = 4'd6; qo[2] = 4'd9; qo[3] = 4'd12;
    for (int i = 0; i < 4; i++) begin qa[i] = $urandom; qb[i] = $urandom; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        model(qo[i-2], qa[i-2], qb[i-2], er, er2, eof, ecf, multi);
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_r",    64'(r),    64'(er));
        chk("b2b_cf",   64'(cf),   64'(ecf));
        chk("b2b_of",   64'(of),   64'(eof));
      end
      if (i < 4) begin start = 1'b1; op = qo[i]; x = qa[i]; y = qb[i]; end
      else start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", 64'(done), 64'd0);

    // random requests
    for (int n = 0; n < 40; n++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run(o, a, b, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
